// File: rtl/memctrl_arb.sv
// memctrl_arb: arbitrates N_PORTS 1/2/4-byte requesters onto one 8-bit RAM/IO bus.
// Latency: read of n bytes completes n+2 cycles after the grant cycle; write n+1.
// Backpressure: rdy_in low freezes the transaction, blocks writes and rewinds read issue.
//
// Ports:
//   clk_in, rst_in (async active-high), rdy_in      clock, reset, bus ready
//   req_i/we_i/len_i/addr_i/wdata_i                 per-port transaction request
//   done_o/rdata_o/busy_o                           completion pulse, read word, busy
//   mem_din/mem_dout/mem_a/mem_wr                   byte-wide memory bus
// Configuration: define MEMCTRL_RR_EN for round-robin arbitration; otherwise
// fixed priority with port 0 highest.
module memctrl_arb #(
    parameter int N_PORTS = 2,
    parameter int PTR_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [N_PORTS-1:0]      req_i,
    input  logic [N_PORTS-1:0]      we_i,
    input  logic [2*N_PORTS-1:0]    len_i,
    input  logic [32*N_PORTS-1:0]   addr_i,
    input  logic [32*N_PORTS-1:0]   wdata_i,
    output logic [N_PORTS-1:0]      done_o,
    output logic [31:0]             rdata_o,
    output logic                    busy_o,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     gnt_q, gnt_d;
    logic                 we_q, we_d;
    logic [2:0]           n_q, n_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [2:0]           ic_q, ic_d;
    logic [2:0]           rc_q, rc_d;
    logic [31:0]          buf_q, buf_d;
    logic [N_PORTS-1:0]   done_q, done_d;
    logic [31:0]          rdata_q, rdata_d;
`ifdef MEMCTRL_RR_EN
    logic [PTR_W-1:0]     ptr_q, ptr_d;
`endif

    // Arbitration result and the fields of the selected port
    logic [PTR_W-1:0]     pick;
    logic                 sel_we;
    logic [1:0]           sel_len;
    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic [N_PORTS-1:0]   gnt_oh;
    logic [2:0]           rd_off;

    always_comb begin
        pick = '0;
`ifdef MEMCTRL_RR_EN
        // Search upward from the port after the last grant; iterating from the
        // farthest candidate down lets the nearest requester win.
        for (int k = N_PORTS; k >= 1; k--) begin
            if (req_i[(int'(ptr_q) + k) % N_PORTS]) begin
                pick = PTR_W'((int'(ptr_q) + k) % N_PORTS);
            end
        end
`else
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                pick = PTR_W'(i);
            end
        end
`endif
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_len   = 2'b00;
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (pick == PTR_W'(i)) begin
                sel_we    = we_i[i];
                sel_len   = len_i[2*i +: 2];
                sel_addr  = addr_i[32*i +: 32];
                sel_wdata = wdata_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            gnt_oh[i] = (gnt_q == PTR_W'(i));
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        n_d     = n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ic_d    = ic_q;
        rc_d    = rc_q;
        buf_d   = buf_q;
        done_d  = done_q;
        rdata_d = rdata_q;
`ifdef MEMCTRL_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (rdy_in && (|req_i)) begin
                    gnt_d   = pick;
                    we_d    = sel_we;
                    case (sel_len)
                        2'b00:   n_d = 3'd1;
                        2'b01:   n_d = 3'd2;
                        default: n_d = 3'd4;
                    endcase
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    ic_d    = 3'd0;
                    rc_d    = 3'd0;
                    buf_d   = 32'd0;
                    state_d = sel_we ? WR : RD;
`ifdef MEMCTRL_RR_EN
                    ptr_d   = pick;
`endif
                end
            end
            RD: begin
                if (!rdy_in) begin
                    // Bytes issued but not yet received are lost; replay them.
                    ic_d = rc_q;
                end else begin
                    if (ic_q < n_q) begin
                        ic_d = ic_q + 3'd1;
                    end
                    // Two-cycle latency: a byte is on mem_din one cycle after issue.
                    if (ic_q > rc_q) begin
                        buf_d[8*rc_q[1:0] +: 8] = mem_din;
                        rc_d = rc_q + 3'd1;
                        if (rc_q == n_q - 3'd1) begin
                            state_d = DONE;
                            rdata_d = buf_d;
                            done_d  = gnt_oh;
                        end
                    end
                end
            end
            WR: begin
                if (rdy_in) begin
                    ic_d = ic_q + 3'd1;
                    if (ic_q == n_q - 3'd1) begin
                        state_d = DONE;
                        rdata_d = 32'd0;
                        done_d  = gnt_oh;
                    end
                end
            end
            DONE: begin
                if (rdy_in) begin
                    state_d = IDLE;
                    done_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus drive: once every read byte is issued, hold the last address.
    always_comb begin
        rd_off   = (ic_q < n_q) ? ic_q : (n_q - 3'd1);
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        case (state_q)
            RD: mem_a = addr_q + {29'd0, rd_off};
            WR: begin
                mem_a    = addr_q + {29'd0, ic_q};
                mem_dout = wdata_q[8*ic_q[1:0] +: 8];
                mem_wr   = rdy_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            n_q     <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ic_q    <= 3'd0;
            rc_q    <= 3'd0;
            buf_q   <= 32'd0;
            done_q  <= '0;
            rdata_q <= 32'd0;
`ifdef MEMCTRL_RR_EN
            ptr_q   <= PTR_W'(N_PORTS - 1);
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ic_q    <= ic_d;
            rc_q    <= rc_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
`ifdef MEMCTRL_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_memctrl_arb.sv
// tb_memctrl_arb: directed bench for memctrl_arb with a two-cycle-latency RAM model.
module tb_memctrl_arb;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [1:0]  req_i = '0;
    logic [1:0]  we_i = '0;
    logic [3:0]  len_i = '0;
    logic [63:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic [1:0]  done_o;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  pipe_q = 8'd0;

    int checks = 0;
    int errors = 0;

    memctrl_arb #(.N_PORTS(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_i(req_i), .we_i(we_i), .len_i(len_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .done_o(done_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // RAM contents: fixed bytes at 0x100..0x103, a simple address hash elsewhere.
    function automatic logic [7:0] mbyte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            default: return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    // Address sampled at one edge; data presented throughout the next cycle.
    always @(posedge clk_in) pipe_q <= mbyte(mem_a);
    assign mem_din = pipe_q;

    task automatic nxt();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        nxt();
        nxt();
        chk("rst_done", {30'd0, done_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        rst_in = 1'b0;
        nxt();

        // Port 0 read, 4 bytes at 0x100
        req_i = 2'b01; we_i = 2'b00; len_i = 4'b0010; addr_i[31:0] = 32'h100;
        #1;
        chk("t1_idle_busy", {31'd0, busy_o}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            nxt();
            chk("t1_mem_a", mem_a, 32'h100 + 32'(c - 1));
            chk("t1_mem_wr", {31'd0, mem_wr}, 32'd0);
        end
        nxt();
        chk("t1_hold_a", mem_a, 32'h103);
        chk("t1_c5_done", {30'd0, done_o}, 32'd0);
        nxt();
        chk("t1_done", {30'd0, done_o}, 32'd1);
        chk("t1_rdata", rdata_o, 32'h44332211);
        req_i = 2'b00;
        nxt();
        chk("t1_after_done", {30'd0, done_o}, 32'd0);
        chk("t1_after_busy", {31'd0, busy_o}, 32'd0);

        // Port 1 write, 2 bytes at 0x30000
        req_i = 2'b10; we_i = 2'b10; len_i = 4'b0100;
        addr_i[63:32] = 32'h30000; wdata_i[63:32] = 32'h0000AABB;
        nxt();
        chk("t2_c1_a", mem_a, 32'h30000);
        chk("t2_c1_dout", {24'd0, mem_dout}, 32'hBB);
        chk("t2_c1_wr", {31'd0, mem_wr}, 32'd1);
        nxt();
        chk("t2_c2_a", mem_a, 32'h30001);
        chk("t2_c2_dout", {24'd0, mem_dout}, 32'hAA);
        chk("t2_c2_wr", {31'd0, mem_wr}, 32'd1);
        nxt();
        chk("t2_done", {30'd0, done_o}, 32'd2);
        chk("t2_rdata", rdata_o, 32'd0);
        chk("t2_c3_wr", {31'd0, mem_wr}, 32'd0);
        req_i = 2'b00; we_i = 2'b00;
        nxt();

        // Both ports request continuously, 1-byte reads
        req_i = 2'b11; len_i = 4'b0000;
        addr_i[31:0] = 32'h200; addr_i[63:32] = 32'h300;
        for (int t = 0; t < 4; t++) begin
            nxt();
            nxt();
            nxt();
`ifdef MEMCTRL_RR_EN
            chk("t3_done", {30'd0, done_o}, (t % 2 == 0) ? 32'd1 : 32'd2);
            chk("t3_rdata", rdata_o, (t % 2 == 0) ? 32'h58 : 32'h59);
`else
            chk("t3_done", {30'd0, done_o}, 32'd1);
            chk("t3_rdata", rdata_o, 32'h58);
`endif
            if (t == 3) req_i = 2'b00;
            nxt();
        end
        chk("t3_idle", {31'd0, busy_o}, 32'd0);

        // 4-byte read stalled for 2 cycles after the first byte is captured
        req_i = 2'b01; len_i = 4'b0010; addr_i[31:0] = 32'h100;
        nxt();
        nxt();
        nxt();
        rdy_in = 1'b0;
        #1;
        chk("t4_stall_wr", {31'd0, mem_wr}, 32'd0);
        chk("t4_stall_busy", {31'd0, busy_o}, 32'd1);
        nxt();
        nxt();
        rdy_in = 1'b1;
        #1;
        chk("t4_reissue_a", mem_a, 32'h101);
        nxt();
        nxt();
        nxt();
        chk("t4_c8_done", {30'd0, done_o}, 32'd0);
        nxt();
        chk("t4_done", {30'd0, done_o}, 32'd1);
        chk("t4_rdata", rdata_o, 32'h44332211);
        req_i = 2'b00;
        rdy_in = 1'b0;
        nxt();
        chk("t4_done_held", {30'd0, done_o}, 32'd1);
        rdy_in = 1'b1;
        nxt();
        chk("t4_done_clear", {30'd0, done_o}, 32'd0);

        // Reset pulsed in cycle 3 of a 4-byte write
        req_i = 2'b01; we_i = 2'b01; len_i = 4'b0010;
        addr_i[31:0] = 32'h400; wdata_i[31:0] = 32'h11223344;
        nxt();
        nxt();
        nxt();
        chk("t5_c3_a", mem_a, 32'h402);
        chk("t5_c3_dout", {24'd0, mem_dout}, 32'h22);
        chk("t5_c3_wr", {31'd0, mem_wr}, 32'd1);
        rst_in = 1'b1;
        #1;
        chk("t5_rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("t5_rst_a", mem_a, 32'd0);
        req_i = 2'b00; we_i = 2'b00;
        nxt();
        rst_in = 1'b0;
        nxt();
        chk("t5_no_done", {30'd0, done_o}, 32'd0);
        chk("t5_idle", {31'd0, busy_o}, 32'd0);

        // 4-byte read wrapping past 0xFFFFFFFF
        req_i = 2'b01; len_i = 4'b0011; addr_i[31:0] = 32'hFFFFFFFE;
        nxt();
        chk("t6_a0", mem_a, 32'hFFFFFFFE);
        nxt();
        chk("t6_a1", mem_a, 32'hFFFFFFFF);
        nxt();
        chk("t6_a2", mem_a, 32'h00000000);
        nxt();
        chk("t6_a3", mem_a, 32'h00000001);
        nxt();
        nxt();
        chk("t6_done", {30'd0, done_o}, 32'd1);
        chk("t6_rdata", rdata_o, 32'h5B5A5A5B);
        req_i = 2'b00;
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
